// File: rtl/register_file_param_if.sv
// Register file access bundle: write port, two read ports, debug taps and status.
// Latency: n/a (wiring only); read data is registered inside the register file.
// Backpressure: none; writes that arrive while busy are discarded and flagged on write_drop.
interface register_file_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clear;
    logic              regwrite;
    logic [ADDR_W-1:0] writereg;
    logic [DATA_W-1:0] writedata;
    logic [ADDR_W-1:0] readreg1;
    logic [ADDR_W-1:0] readreg2;
    logic [DATA_W-1:0] readdata1;
    logic [DATA_W-1:0] readdata2;
    logic [DATA_W-1:0] debug_data;
    logic              done_flag;
    logic              busy;
    logic              write_drop;

    // master: the block issuing reads/writes
    modport master (
        output clear, regwrite, writereg, writedata, readreg1, readreg2,
        input  readdata1, readdata2, debug_data, done_flag, busy, write_drop
    );

    // slave: the register file itself
    modport slave (
        input  clear, regwrite, writereg, writedata, readreg1, readreg2,
        output readdata1, readdata2, debug_data, done_flag, busy, write_drop
    );
endinterface

// File: rtl/register_file_param.sv
// Parameterised register file with a clear sweep, two read ports and debug/done taps.
// Latency: 1 cycle address-to-data, same-cycle accepted writes bypass to the read outputs.
// Backpressure: none; writes during a sweep or alongside clear are dropped and pulse write_drop.
//
// Ports: clock, reset_n (async active-low), bus (slave side of register_file_param_if):
//   clear/regwrite/writereg/writedata/readreg1/readreg2 in;
//   readdata1/readdata2/debug_data/done_flag/busy/write_drop out.
module register_file_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_R0   = 1,
    parameter int DEBUG_IDX = 20,
    parameter int DONE_IDX  = 26
) (
    input  logic                  clock,
    input  logic                  reset_n,
    register_file_param_if.slave  bus
);
    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DBG_A  = ADDR_W'(DEBUG_IDX);
    localparam logic [ADDR_W-1:0] DONE_A = ADDR_W'(DONE_IDX);

    typedef enum logic {SWEEP, IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Storage is deliberately not reset; the sweep after reset zeroes it.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_sweep;
    logic              wr_r0;
    logic              wr_acc;
    logic              wr_drop;

    logic [DATA_W-1:0] rd1_d, rd2_d, dbg_d, done_d;
    logic [DATA_W-1:0] rd1_q, rd2_q, dbg_q;
    logic              done_q;
    logic              drop_q;

    assign in_sweep = (state_q == SWEEP);
    // Writes to a hard-wired zero entry are silently ignored, not counted as drops.
    assign wr_r0    = (ZERO_R0 != 0) && (bus.writereg == '0);
    assign wr_drop  = bus.regwrite && (in_sweep || bus.clear);
    assign wr_acc   = bus.regwrite && !in_sweep && !bus.clear && !wr_r0;

    // Read value as seen after this edge: zero entry, then bypass, then storage.
    function automatic logic [DATA_W-1:0] rd_sel(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              acc,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        logic [DATA_W-1:0] v;
        v = stored;
        if ((ZERO_R0 != 0) && (a == '0)) begin
            v = '0;
        end else if (acc && (wa == a)) begin
            v = wd;
        end
        return v;
    endfunction

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_A) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.clear) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage: the sweep owns the array; normal writes only outside a sweep.
    always_ff @(posedge clock) begin
        if (in_sweep) begin
            mem[cnt_q] <= '0;
        end else if (wr_acc) begin
            mem[bus.writereg] <= bus.writedata;
        end
    end

    always_comb begin
        rd1_d  = rd_sel(bus.readreg1, mem[bus.readreg1], wr_acc, bus.writereg, bus.writedata);
        rd2_d  = rd_sel(bus.readreg2, mem[bus.readreg2], wr_acc, bus.writereg, bus.writedata);
        dbg_d  = rd_sel(DBG_A, mem[DBG_A], wr_acc, bus.writereg, bus.writedata);
        done_d = rd_sel(DONE_A, mem[DONE_A], wr_acc, bus.writereg, bus.writedata);
    end

    // Registered outputs; held at zero throughout a sweep.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd1_q  <= '0;
            rd2_q  <= '0;
            dbg_q  <= '0;
            done_q <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= wr_drop;
            if (in_sweep) begin
                rd1_q  <= '0;
                rd2_q  <= '0;
                dbg_q  <= '0;
                done_q <= 1'b0;
            end else begin
                rd1_q  <= rd1_d;
                rd2_q  <= rd2_d;
                dbg_q  <= dbg_d;
                done_q <= done_d[0];
            end
        end
    end

    assign bus.readdata1  = rd1_q;
    assign bus.readdata2  = rd2_q;
    assign bus.debug_data = dbg_q;
    assign bus.done_flag  = done_q;
    assign bus.write_drop = drop_q;
    assign bus.busy       = in_sweep;
endmodule

// File: tb/tb_register_file_param.sv
// Bench for register_file_param: directed vector table, hand-written reset/clear
// sequences and a randomized run against a write-first array model of the file.
module tb_register_file_param;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int DBG   = 20;
    localparam int DONE  = 26;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    register_file_param_if #(.DATA_W(DW), .ADDR_W(AW)) rf_if ();

    register_file_param #(
        .DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1), .DEBUG_IDX(DBG), .DONE_IDX(DONE)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (rf_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: plain array plus count of sweep cycles still to run.
    logic [DW-1:0] m_mem [DEPTH];
    int            sweep_left;
    logic [DW-1:0] e_rd1, e_rd2, e_dbg;
    logic          e_done, e_drop, e_busy;

    typedef struct {
        logic          clr;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
        logic [DW-1:0] edbg;
        logic          edone;
        logic          edrop;
        logic          ebusy;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int a);
        return (a == 0) ? '0 : m_mem[a];
    endfunction

    task automatic m_reset();
        e_rd1 = '0; e_rd2 = '0; e_dbg = '0; e_done = 1'b0; e_drop = 1'b0;
        e_busy = 1'b1;
        sweep_left = DEPTH;
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_edge();
        logic [DW-1:0] t;
        if (!reset_n) begin
            m_reset();
            return;
        end
        if (sweep_left > 0) begin
            m_mem[DEPTH - sweep_left] = '0;
            sweep_left--;
            e_rd1 = '0; e_rd2 = '0; e_dbg = '0; e_done = 1'b0;
            e_drop = rf_if.regwrite;
        end else begin
            if (rf_if.clear) begin
                e_drop = rf_if.regwrite;
                sweep_left = DEPTH;
            end else begin
                e_drop = 1'b0;
                if (rf_if.regwrite && rf_if.writereg != 0)
                    m_mem[rf_if.writereg] = rf_if.writedata;
            end
            // Write-first: an accepted write is already in the array here.
            e_rd1  = m_read(rf_if.readreg1);
            e_rd2  = m_read(rf_if.readreg2);
            e_dbg  = m_read(DBG);
            t      = m_read(DONE);
            e_done = t[0];
        end
        e_busy = (sweep_left > 0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rd1"},  rf_if.readdata1,  e_rd1);
        chk({tag, ".rd2"},  rf_if.readdata2,  e_rd2);
        chk({tag, ".dbg"},  rf_if.debug_data, e_dbg);
        chk({tag, ".done"}, DW'(rf_if.done_flag),  DW'(e_done));
        chk({tag, ".drop"}, DW'(rf_if.write_drop), DW'(e_drop));
        chk({tag, ".busy"}, DW'(rf_if.busy),       DW'(e_busy));
    endtask

    task automatic drive(input logic c, input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        rf_if.clear     = c;
        rf_if.regwrite  = we;
        rf_if.writereg  = wa;
        rf_if.writedata = wd;
        rf_if.readreg1  = r1;
        rf_if.readreg2  = r2;
    endtask

    // Runs from the first sweep cycle until busy drops; optionally injects a write at one cycle.
    task automatic count_sweep(input string tag, input int inject_at);
        int n = 0;
        do begin
            if (n == inject_at) drive(0, 1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd0);
            else                drive(0, 0, 5'd0, 32'h0, 5'd7, 5'd0);
            tick();
            check_model($sformatf("%s.c%0d", tag, n));
            n++;
        end while (rf_if.busy && n < 100);
        chk({tag, ".len"}, DW'(n), DW'(DEPTH));
    endtask

    task automatic assert_reset(input string tag);
        reset_n = 1'b0;
        #1;
        m_reset();
        check_model(tag);
    endtask

    initial begin
        vt[0] = '{0,1,5'd5, 32'hDEADBEEF,5'd0, 5'd0, 32'h0,       32'h0,       32'h0,       0,0,0};
        vt[1] = '{0,0,5'd0, 32'h0,       5'd5, 5'd5, 32'hDEADBEEF,32'hDEADBEEF,32'h0,       0,0,0};
        vt[2] = '{0,1,5'd20,32'h12345678,5'd20,5'd20,32'h12345678,32'h12345678,32'h12345678,0,0,0};
        vt[3] = '{0,1,5'd0, 32'hFFFFFFFF,5'd0, 5'd5, 32'h0,       32'hDEADBEEF,32'h12345678,0,0,0};
        vt[4] = '{0,0,5'd0, 32'h0,       5'd0, 5'd20,32'h0,       32'h12345678,32'h12345678,0,0,0};
        vt[5] = '{0,1,5'd26,32'h3,       5'd26,5'd1, 32'h3,       32'h0,       32'h12345678,1,0,0};
        vt[6] = '{0,0,5'd0, 32'h0,       5'd26,5'd20,32'h3,       32'h12345678,32'h12345678,1,0,0};
        vt[7] = '{0,1,5'd26,32'h2,       5'd5, 5'd26,32'hDEADBEEF,32'h2,       32'h12345678,0,0,0};

        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        drive(0, 0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Power-on reset, then the post-reset sweep.
        assert_reset("por");
        tick(); check_model("por_hold");
        tick(); check_model("por_hold2");
        reset_n = 1'b1;
        count_sweep("por_sweep", -1);

        // Every entry reads zero after the sweep.
        for (int i = 0; i < DEPTH; i += 2) begin
            drive(0, 0, 5'd0, 32'h0, AW'(i), AW'(i + 1));
            tick();
            chk($sformatf("zero_rd1_%0d", i),     rf_if.readdata1, 32'h0);
            chk($sformatf("zero_rd2_%0d", i + 1), rf_if.readdata2, 32'h0);
        end

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            drive(vt[i].clr, vt[i].we, vt[i].wa, vt[i].wd, vt[i].r1, vt[i].r2);
            tick();
            chk($sformatf("vec%0d.rd1", i),  rf_if.readdata1,  vt[i].e1);
            chk($sformatf("vec%0d.rd2", i),  rf_if.readdata2,  vt[i].e2);
            chk($sformatf("vec%0d.dbg", i),  rf_if.debug_data, vt[i].edbg);
            chk($sformatf("vec%0d.done", i), DW'(rf_if.done_flag),  DW'(vt[i].edone));
            chk($sformatf("vec%0d.drop", i), DW'(rf_if.write_drop), DW'(vt[i].edrop));
            chk($sformatf("vec%0d.busy", i), DW'(rf_if.busy),       DW'(vt[i].ebusy));
        end

        // Clear together with a write to the done entry: write dropped, old data read.
        drive(1, 1, 5'd26, 32'h1, 5'd26, 5'd20);
        tick();
        check_model("clrwr");
        chk("clrwr.drop_abs", DW'(rf_if.write_drop), 32'h1);
        chk("clrwr.rd1_abs",  rf_if.readdata1, 32'h2);
        chk("clrwr.done_abs", DW'(rf_if.done_flag), 32'h0);
        count_sweep("clr_sweep", 5);
        drive(0, 0, 5'd0, 32'h0, 5'd26, 5'd7);
        tick();
        chk("post_clr.r26", rf_if.readdata1, 32'h0);
        chk("post_clr.r7",  rf_if.readdata2, 32'h0);
        chk("post_clr.done", DW'(rf_if.done_flag), 32'h0);

        // Reset while idle with live read data: outputs drop at once.
        drive(0, 1, 5'd20, 32'hCAFEF00D, 5'd20, 5'd20);
        tick();
        check_model("pre_rst");
        drive(0, 0, 5'd0, 32'h0, 5'd20, 5'd20);
        assert_reset("idle_rst");
        tick(); check_model("idle_rst_hold");
        reset_n = 1'b1;
        count_sweep("idle_rst_sweep", -1);

        // Reset at sweep cycle 10 with a dropped write in flight.
        drive(1, 0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick(); check_model("ms_clr");
        for (int i = 0; i < 10; i++) begin
            if (i == 9) drive(0, 1, 5'd3, 32'h33, 5'd3, 5'd0);
            else        drive(0, 0, 5'd0, 32'h0, 5'd3, 5'd0);
            tick();
            check_model($sformatf("ms_c%0d", i));
        end
        chk("ms.drop_before_rst", DW'(rf_if.write_drop), 32'h1);
        drive(0, 0, 5'd0, 32'h0, 5'd3, 5'd0);
        assert_reset("ms_rst");
        tick(); check_model("ms_rst_hold");
        reset_n = 1'b1;
        count_sweep("ms_sweep", -1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a [3];
            for (int k = 0; k < 3; k++) begin
                case ($urandom_range(0, 4))
                    0: a[k] = 5'd0;
                    1: a[k] = 5'd20;
                    2: a[k] = 5'd26;
                    default: a[k] = AW'($urandom_range(0, DEPTH - 1));
                endcase
            end
            drive($urandom_range(0, 99) < 2, 1'($urandom), a[0],
                  ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 1)) : DW'($urandom),
                  a[1], ($urandom_range(0, 3) == 0) ? a[0] : a[2]);
            tick();
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
